// File: rtl/sram_phase_sequencer.sv
// Single-port SRAM owner: sequences UART load -> Milestone1 decode -> VGA display with drain gaps; optional watchdog via SRAM_PHASE_WATCHDOG_EN.
// Latency: phase changes one cycle after Start/done; client SRAM signals pass through combinationally while owned.
// Backpressure: none; clients are gated by level enables, and non-owner done/Start outside IDLE/DISPLAY are ignored.
module sram_phase_sequencer #(
    parameter int                  DRAIN_CYCLES = 2,
    parameter int                  WD_WIDTH     = 24,
    parameter logic [WD_WIDTH-1:0] WD_LIMIT     = 24'hFF_FFFF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        UART_done,
    input  logic        M1_done,
    input  logic [17:0] UART_address,
    input  logic [17:0] M1_address,
    input  logic [17:0] VGA_address,
    input  logic [15:0] UART_write_data,
    input  logic [15:0] M1_write_data,
    input  logic        UART_we_n,
    input  logic        M1_we_n,
    output logic        UART_enable,
    output logic        M1_Enable,
    output logic        VGA_enable,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  Phase,
    output logic        Busy,
    output logic        Error
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DECODE  = 3'd2,
        S_DISPLAY = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    state_t          next_phase_q, next_phase_d;
    logic [DW-1:0]   drain_q, drain_d;

`ifdef SRAM_PHASE_WATCHDOG_EN
    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic                error_q, error_d;
`else
    wire wd_unused = ^WD_LIMIT;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            next_phase_q <= S_IDLE;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            next_phase_q <= next_phase_d;
            drain_q      <= drain_d;
        end
    end

`ifdef SRAM_PHASE_WATCHDOG_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        next_phase_d = next_phase_q;
        drain_d      = drain_q;
`ifdef SRAM_PHASE_WATCHDOG_EN
        wd_d         = wd_q;
        error_d      = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_LOAD;
`ifdef SRAM_PHASE_WATCHDOG_EN
                    wd_d    = '0;
                    error_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                // done outranks the watchdog so a finish on the last budgeted cycle is not flagged
                if (UART_done) begin
                    state_d      = S_DRAIN;
                    next_phase_d = S_DECODE;
                    drain_d      = DRAIN_LOAD;
                end
`ifdef SRAM_PHASE_WATCHDOG_EN
                else if (wd_q == WD_LIMIT) begin
                    state_d      = S_DRAIN;
                    next_phase_d = S_IDLE;
                    drain_d      = DRAIN_LOAD;
                    error_d      = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DECODE: begin
                if (M1_done) begin
                    state_d      = S_DRAIN;
                    next_phase_d = S_DISPLAY;
                    drain_d      = DRAIN_LOAD;
                end
`ifdef SRAM_PHASE_WATCHDOG_EN
                else if (wd_q == WD_LIMIT) begin
                    state_d      = S_DRAIN;
                    next_phase_d = S_IDLE;
                    drain_d      = DRAIN_LOAD;
                    error_d      = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DISPLAY: begin
                if (Start) begin
                    state_d      = S_DRAIN;
                    next_phase_d = S_LOAD;
                    drain_d      = DRAIN_LOAD;
`ifdef SRAM_PHASE_WATCHDOG_EN
                    error_d      = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = next_phase_q;
`ifdef SRAM_PHASE_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port ownership is decoded from the registered state only, so reset parks the SRAM immediately.
    always_comb begin
        UART_enable     = 1'b0;
        M1_Enable       = 1'b0;
        VGA_enable      = 1'b0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state_q)
            S_LOAD: begin
                UART_enable     = 1'b1;
                SRAM_address    = UART_address;
                SRAM_write_data = UART_write_data;
                SRAM_we_n       = UART_we_n;
            end
            S_DECODE: begin
                M1_Enable       = 1'b1;
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
                SRAM_we_n       = M1_we_n;
            end
            S_DISPLAY: begin
                VGA_enable   = 1'b1;
                SRAM_address = VGA_address;
            end
            default: ;
        endcase
    end

    assign Phase = state_q;
    assign Busy  = (state_q == S_LOAD) || (state_q == S_DECODE) || (state_q == S_DRAIN);

`ifdef SRAM_PHASE_WATCHDOG_EN
    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Scoreboard bench for sram_phase_sequencer: expected per-cycle outputs are queued by the stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_sram_phase_sequencer;

    localparam logic [17:0] UA = 18'h00123;
    localparam logic [15:0] UW = 16'hBEEF;
    localparam logic [17:0] MA = 18'h3FFFF;
    localparam logic [15:0] MW = 16'h1234;
    localparam logic [17:0] VA = 18'h2AAAA;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic        UART_done = 1'b0;
    logic        M1_done = 1'b0;
    logic [17:0] UART_address = UA;
    logic [17:0] M1_address = MA;
    logic [17:0] VGA_address = VA;
    logic [15:0] UART_write_data = UW;
    logic [15:0] M1_write_data = MW;
    logic        UART_we_n = 1'b0;
    logic        M1_we_n = 1'b0;
    logic        UART_enable, M1_Enable, VGA_enable;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [2:0]  Phase;
    logic        Busy, Error;

    sram_phase_sequencer #(
        .DRAIN_CYCLES(2),
        .WD_WIDTH(24),
        .WD_LIMIT(24'd100)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start),
        .UART_done(UART_done), .M1_done(M1_done),
        .UART_address(UART_address), .M1_address(M1_address), .VGA_address(VGA_address),
        .UART_write_data(UART_write_data), .M1_write_data(M1_write_data),
        .UART_we_n(UART_we_n), .M1_we_n(M1_we_n),
        .UART_enable(UART_enable), .M1_Enable(M1_Enable), .VGA_enable(VGA_enable),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .Phase(Phase), .Busy(Busy), .Error(Error)
    );

    typedef struct packed {
        logic [2:0]  phase;
        logic        uen, men, ven, busy, err, we_n;
        logic [17:0] addr;
        logic [15:0] wdata;
    } obs_t;

    typedef struct {
        int    cyc;
        string name;
        obs_t  exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n;
    obs_t obs;

    assign obs = {Phase, UART_enable, M1_Enable, VGA_enable, Busy, Error, SRAM_we_n,
                  SRAM_address, SRAM_write_data};

    always #5 Clock = ~Clock;

    // Cycle k is the interval following the k-th rising edge after reset release.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    function automatic obs_t model(int ph, bit err);
        obs_t o;
        o       = '0;
        o.phase = 3'(ph);
        o.err   = err;
        o.we_n  = 1'b1;
        case (ph)
            1: begin o.uen = 1; o.busy = 1; o.addr = UA; o.we_n = 0; o.wdata = UW; end
            2: begin o.men = 1; o.busy = 1; o.addr = MA; o.we_n = 0; o.wdata = MW; end
            3: begin o.ven = 1; o.addr = VA; end
            4: o.busy = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (phase got %0d required %0d)",
                     name, got, exp, got.phase, exp.phase);
        end
    endtask

    task automatic push(int cyc, string name, int ph, bit err = 1'b0);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.exp  = model(ph, err);
        sb.push_back(e);
    endtask

    task automatic at_cycle(int c);
        do @(negedge Clock); while (edge_n < c);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
                cur = sb.pop_front();
                if (cur.cyc < edge_n) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: not sampled at cycle %0d (now %0d)", cur.name, cur.cyc, edge_n);
                end else begin
                    check(cur.name, obs, cur.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached with %0d expectations pending", sb.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        push(0,  "reset_state", 0);
        push(3,  "idle", 0);
        push(5,  "idle_before_start", 0);
        push(6,  "load_entry", 1);
        push(11, "m1_done_ignored_in_load", 1);
        push(12, "m1_done_ignored_in_load_2", 1);
        push(20, "load_last", 1);
        push(21, "drain_after_load_1", 4);
        push(22, "drain_after_load_2", 4);
        push(23, "decode_entry", 2);
        push(31, "start_ignored_in_decode", 2);
        push(32, "start_ignored_in_decode_2", 2);
        push(41, "uart_done_ignored_in_decode", 2);
        push(60, "decode_last", 2);
        push(61, "drain_after_decode_1", 4);
        push(62, "drain_after_decode_2", 4);
        push(63, "display_entry", 3);
        push(80, "display_hold", 3);
        push(81, "restart_drain_1", 4);
        push(82, "restart_drain_2", 4);
        push(83, "reload_entry", 1);
        push(91, "done_wins_over_start", 4);
        push(92, "start_ignored_in_drain", 4);
        push(93, "decode_after_dropped_start", 2);
        push(94, "decode_hold", 2);

        repeat (2) @(negedge Clock);
        #1 Resetn = 1'b1;

        at_cycle(5);  Start = 1'b1;
        at_cycle(6);  Start = 1'b0;
        at_cycle(10); M1_done = 1'b1;
        at_cycle(11); M1_done = 1'b0;
        at_cycle(20); UART_done = 1'b1;
        at_cycle(21); UART_done = 1'b0;
        at_cycle(30); Start = 1'b1;
        at_cycle(31); Start = 1'b0;
        at_cycle(40); UART_done = 1'b1;
        at_cycle(41); UART_done = 1'b0;
        at_cycle(60); M1_done = 1'b1;
        at_cycle(61); M1_done = 1'b0;
        at_cycle(80); Start = 1'b1;
        at_cycle(81); Start = 1'b0;
        at_cycle(90); UART_done = 1'b1; Start = 1'b1;
        at_cycle(91); UART_done = 1'b0;
        at_cycle(92); Start = 1'b0;

        // Asynchronous reset while M1 is writing must park the port before any clock edge.
        at_cycle(100);
        check("decode_write_before_reset", obs, model(2, 1'b0));
        Resetn = 1'b0;
        #1;
        check("async_reset_mid_decode", obs, model(0, 1'b0));
        push(0, "reset_hold", 0);
        repeat (2) @(negedge Clock);
        #1 Resetn = 1'b1;

`ifdef SRAM_PHASE_WATCHDOG_EN
        push(5,   "wd_idle", 0);
        push(6,   "wd_load_entry", 1);
        push(106, "wd_last_load_cycle", 1, 1'b0);
        push(107, "wd_error_drain_1", 4, 1'b1);
        push(108, "wd_error_drain_2", 4, 1'b1);
        push(109, "wd_idle_error_sticky", 0, 1'b1);
        push(115, "wd_error_held", 0, 1'b1);
        push(116, "wd_start_clears_error", 1, 1'b0);
        at_cycle(5);   Start = 1'b1;
        at_cycle(6);   Start = 1'b0;
        at_cycle(115); Start = 1'b1;
        at_cycle(116); Start = 1'b0;
`else
        push(5,   "nowd_idle", 0);
        push(6,   "nowd_load_entry", 1);
        push(200, "nowd_load_waits_forever", 1, 1'b0);
        at_cycle(5); Start = 1'b1;
        at_cycle(6); Start = 1'b0;
`endif

        for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge Clock);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_scoreboard: %0d expectations left, required 0", sb.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_phase_sequencer.md
# sram_phase_sequencer

Top-level scheduler for the image decompressor's single-port external SRAM. It owns the SRAM port and sequences three clients in order: the UART loader writes the compressed image, Milestone1 runs the YUV→RGB upsample/colour-space conversion, and the VGA reader displays the result. Only one client drives the SRAM at any time. Drain gaps between phases absorb the SRAM's 2-cycle read latency, so no stale read data crosses an ownership change.

## Interface
Parameters:
- DRAIN_CYCLES, 2, idle cycles inserted on every ownership change (min 1)
- WD_WIDTH, 24, watchdog counter width
- WD_LIMIT, 24'hFF_FFFF, cycle budget for the LOAD and DECODE phases

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Resetn  in  1  reset, asynchronous, active-low
- Start  in  1  single-cycle start/restart pulse
- UART_done  in  1  loader finished; level or pulse
- M1_done  in  1  Milestone1 finished; level or pulse
- UART_address / M1_address / VGA_address  in  18 each  client addresses
- UART_write_data / M1_write_data  in  16 each  client write data
- UART_we_n / M1_we_n  in  1 each  client write enables, active-low
- UART_enable / M1_Enable / VGA_enable  out  1 each  client run enables, level
- SRAM_address  out  18  to SRAM
- SRAM_write_data  out  16  to SRAM
- SRAM_we_n  out  1  to SRAM, active-low
- Phase  out  3  0 IDLE, 1 LOAD, 2 DECODE, 3 DISPLAY, 4 DRAIN
- Busy  out  1  high in LOAD, DECODE, or DRAIN
- Error  out  1  sticky watchdog error

## Operation
- FSM states: S_IDLE, S_LOAD, S_DECODE, S_DISPLAY, S_DRAIN. A next_phase register selects the state entered after S_DRAIN.
- S_IDLE:
  - Start → S_LOAD.
  - Error clears on that same Start.
- S_LOAD:
  - UART_enable=1.
  - UART_done=1 → S_DRAIN with next_phase=DECODE.
- S_DECODE:
  - M1_Enable=1.
  - M1_done=1 → S_DRAIN with next_phase=DISPLAY.
- S_DISPLAY:
  - VGA_enable=1. The phase persists indefinitely.
  - Start → S_DRAIN with next_phase=LOAD.
- S_DRAIN:
  - All enables 0.
  - A down-counter loaded with DRAIN_CYCLES-1 runs; at 0 the FSM enters next_phase.
- SRAM mux is combinational from the registered state only:
  - LOAD: UART bundle.
  - DECODE: M1 bundle.
  - DISPLAY: VGA_address, we_n=1, write_data=0.
  - IDLE/DRAIN: address 0, we_n=1, write_data 0.
- A done from a non-owning client is ignored.
- Start during LOAD, DECODE, or DRAIN is ignored.
- Start and done asserted in the same cycle: done wins, Start is dropped.

## Timing
- Reset values:
  - State S_IDLE, Phase=0.
  - All enables 0, Busy 0, Error 0.
  - SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
  - Counters 0.
- Start sampled at edge N → Phase=1 and UART_enable=1 from edge N+1.
- Done sampled at edge N:
  - Enable falls at N+1.
  - Phase=4 for exactly DRAIN_CYCLES cycles.
  - Next enable rises at N+1+DRAIN_CYCLES.
- Client SRAM signals pass to the SRAM with zero cycles of latency while the client owns the port.
- Asynchronous reset mid-phase:
  - All outputs go to their reset values immediately.
  - A write in progress is aborted; we_n is forced to 1.

## Configuration
- Macro: SRAM_PHASE_WATCHDOG_EN.
- Defined:
  - A WD_WIDTH counter clears on entry to LOAD/DECODE and increments each cycle in those phases.
  - On reaching WD_LIMIT: Error=1 and the FSM goes to S_DRAIN with next_phase=IDLE.
  - Error stays set until the next accepted Start or reset.
- Undefined: no counter is instantiated, Error is tied to 0, and LOAD/DECODE wait forever for done.

## Test plan
- Reset, then Start at cycle 5, UART_done at 20, M1_done at 60 → Phase sequence 1,4,4,2,4,4,3, with the enable edges at cycles 6/21/23/61/63.
- In LOAD, drive UART_address=0x00123, UART_we_n=0, M1_address=0x3FFFF → SRAM_address=0x00123, SRAM_we_n=0; in DRAIN, SRAM_address=0 and SRAM_we_n=1.
- M1_done pulsed during LOAD, and Start pulsed during DECODE → no state change, Phase unchanged.
- In DISPLAY, assert Start → 2 drain cycles, then LOAD with UART_enable=1 and VGA_enable=0.
- Watchdog build with WD_LIMIT=100, Start, UART_done never asserted → Error=1 at cycle 101 after entry, then DRAIN, then IDLE; the next Start clears Error.
- Resetn asserted mid-DECODE with M1_we_n=0 → SRAM_we_n=1 and M1_Enable=0 before the next clock edge.
